// File: rtl/door_pkg.sv
// Shared constants and state encoding for the door access arbiter and door_control.
package door_pkg;

  localparam int DEFAULT_PW_W    = 14;
  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REPORT,
    S_LOCKED
  } state_t;

endpackage

// File: rtl/door_access_arbiter_if.sv
// Bundle between the keypad requesters, the arbiter and door_control's password port.
interface door_access_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int PW_W    = door_pkg::DEFAULT_PW_W
);

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*PW_W-1:0] req_pw;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      done;
  logic                    pass;
  logic                    busy;
  logic                    lockout;
  logic                    dc_submit;
  logic [PW_W-1:0]         dc_password;
  logic                    dc_unlock;
  logic                    dc_alarm;

  // The arbiter is the slave: it serves the requesters and fronts door_control.
  modport slave (
    input  req, req_pw, dc_unlock, dc_alarm,
    output gnt, done, pass, busy, lockout, dc_submit, dc_password
  );

  modport master (
    output req, req_pw, dc_unlock, dc_alarm,
    input  gnt, done, pass, busy, lockout, dc_submit, dc_password
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/door_access_arbiter.sv
// Round-robin arbiter sharing door_control's password port among keypad requesters,
// with a bounded wait for the unlock/alarm answer and a lockout while alarmed.
module door_access_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int PW_W         = door_pkg::DEFAULT_PW_W,
  parameter int RESP_TIMEOUT = door_pkg::DEFAULT_TIMEOUT
) (
  input logic                 clk,
  input logic                 reset,
  door_access_arbiter_if.slave bus
);

  import door_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(RESP_TIMEOUT);

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [TMR_W-1:0]     timer_q;
  logic [PW_W-1:0]      pw_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 pass_q;
  logic                 busy_q;
  logic                 lockout_q;
  logic                 submit_q;
  logic                 alarm_seen_q;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // done and pass default low so they only ever pulse for the single REPORT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      pw_q         <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      lockout_q    <= 1'b0;
      submit_q     <= 1'b0;
      alarm_seen_q <= 1'b0;
    end else begin
      submit_q <= 1'b0;
      done_q   <= '0;
      pass_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.dc_alarm) begin
            state_q   <= S_LOCKED;
            lockout_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (pick_valid) begin
            state_q  <= S_ISSUE;
            idx_q    <= pick_idx;
            pw_q     <= bus.req_pw[int'(pick_idx)*PW_W +: PW_W];
            gnt_q    <= NUM_REQ'(1) << pick_idx;
            submit_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          timer_q <= '0;
        end
        S_WAIT: begin
          if (bus.dc_unlock) begin
            state_q <= S_REPORT;
            done_q  <= gnt_q;
            pass_q  <= 1'b1;
          end else if (bus.dc_alarm) begin
            state_q      <= S_REPORT;
            done_q       <= gnt_q;
            alarm_seen_q <= 1'b1;
          end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
            state_q <= S_REPORT;
            done_q  <= gnt_q;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_REPORT: begin
          gnt_q <= '0;
          ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          if (alarm_seen_q || bus.dc_alarm) begin
            state_q   <= S_LOCKED;
            lockout_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LOCKED: begin
          alarm_seen_q <= 1'b0;
          if (!bus.dc_alarm) begin
            state_q   <= S_IDLE;
            lockout_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.busy        = busy_q;
  assign bus.lockout     = lockout_q;
  assign bus.dc_submit   = submit_q;
  assign bus.dc_password = pw_q;

endmodule

// File: tb/tb_door_access_arbiter.sv
// Directed bench for door_access_arbiter: door_control responses are driven by hand per scenario.
module tb_door_access_arbiter;

  localparam int NUM_REQ = 3;
  localparam int PW_W    = 14;

  localparam logic [PW_W-1:0] PW_A = 14'd1111;
  localparam logic [PW_W-1:0] PW_B = 14'd1234;
  localparam logic [PW_W-1:0] PW_C = 14'd9012;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;
  int submitCount = 0;
  int doneCount = 0;
  int multiGnt = 0;

  door_access_arbiter_if #(.NUM_REQ(NUM_REQ), .PW_W(PW_W)) bus ();

  door_access_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .PW_W         (PW_W),
    .RESP_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Running tallies of submit pulses, done pulses and multi-hot grants.
  always @(negedge clk) begin
    if (bus.dc_submit === 1'b1) submitCount++;
    doneCount += $countones(bus.done);
    if ($countones(bus.gnt) > 1) multiGnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] reqVec,
                               input logic [PW_W-1:0] pw2,
                               input logic [PW_W-1:0] pw1,
                               input logic [PW_W-1:0] pw0);
    bus.req_pw = {pw2, pw1, pw0};
    bus.req    = reqVec;
  endtask

  task automatic doReset();
    bus.req       = '0;
    bus.dc_unlock = 1'b0;
    bus.dc_alarm  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitForSubmit(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.dc_submit === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic waitForDone(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done !== '0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    bus.req = '0; bus.req_pw = '0; bus.dc_unlock = 1'b0; bus.dc_alarm = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    obs = {bus.gnt, bus.done, bus.pass, bus.busy, bus.lockout, bus.dc_submit, bus.dc_password};
    testsRun++; if (obs !== '0) begin testsFailed++; $display("[TB] FAIL reset_outputs: got %h, expected 0", obs); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    testsRun++; if ({bus.busy, bus.lockout, bus.gnt} !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_idle: got busy=%b lockout=%b gnt=%b, expected all 0", bus.busy, bus.lockout, bus.gnt); end
    // Alarm in IDLE beats a pending request
    applyStimulus(3'b001, PW_C, PW_B, PW_A);
    bus.dc_alarm = 1'b1;
    @(negedge clk);
    testsRun++; if ({bus.lockout, bus.busy, bus.gnt, bus.dc_submit} !== {1'b1, 1'b1, 3'b000, 1'b0}) begin testsFailed++; $display("[TB] FAIL idle_alarm_priority: got lockout=%b busy=%b gnt=%b submit=%b, expected 1 1 000 0", bus.lockout, bus.busy, bus.gnt, bus.dc_submit); end
    bus.req = '0;
    bus.dc_alarm = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++; if ({bus.lockout, bus.busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL alarm_release: got lockout=%b busy=%b, expected 0 0", bus.lockout, bus.busy); end
  endtask

  task automatic test_correct_password();
    bit seen;
    int subStart;
    doReset();
    subStart = submitCount;
    applyStimulus(3'b001, PW_C, PW_B, PW_A);
    waitForSubmit(seen);
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL t1_submit: seen=%0b, expected 1", seen); end
    testsRun++; if (bus.dc_password !== PW_A || bus.gnt !== 3'b001) begin testsFailed++; $display("[TB] FAIL t1_issue: got pw=%0d gnt=%b, expected pw=1111 gnt=001", bus.dc_password, bus.gnt); end
    @(negedge clk);
    testsRun++; if ({bus.dc_submit, bus.gnt, bus.done, bus.dc_password} !== {1'b0, 3'b001, 3'b000, PW_A}) begin testsFailed++; $display("[TB] FAIL t1_wait: got submit=%b gnt=%b done=%b pw=%0d, expected 0 001 000 1111", bus.dc_submit, bus.gnt, bus.done, bus.dc_password); end
    @(negedge clk);
    bus.dc_unlock = 1'b1;
    @(negedge clk);
    testsRun++; if ({bus.done, bus.pass, bus.gnt} !== {3'b001, 1'b1, 3'b001}) begin testsFailed++; $display("[TB] FAIL t1_report: got done=%b pass=%b gnt=%b, expected 001 1 001", bus.done, bus.pass, bus.gnt); end
    bus.dc_unlock = 1'b0;
    bus.req = '0;
    repeat (3) @(negedge clk);
    testsRun++; if ({bus.busy, bus.gnt, bus.done, bus.pass} !== 8'b0) begin testsFailed++; $display("[TB] FAIL t1_idle: got busy=%b gnt=%b done=%b pass=%b, expected all 0", bus.busy, bus.gnt, bus.done, bus.pass); end
    testsRun++; if (submitCount - subStart != 1) begin testsFailed++; $display("[TB] FAIL t1_submit_count: got %0d, expected 1", submitCount - subStart); end
  endtask

  task automatic test_round_robin();
    bit seen;
    bit doneSeen;
    int subStart;
    int doneStart;
    int multiStart;
    logic [PW_W-1:0] pwTab [3];
    logic [2:0] expGnt;
    pwTab[0] = PW_A; pwTab[1] = PW_B; pwTab[2] = PW_C;
    doReset();
    subStart = submitCount; doneStart = doneCount; multiStart = multiGnt;
    applyStimulus(3'b111, PW_C, PW_B, PW_A);
    for (int n = 0; n < 6; n++) begin
      expGnt = 3'b001 << (n % 3);
      waitForSubmit(seen);
      testsRun++; if (!seen || bus.gnt !== expGnt || bus.dc_password !== pwTab[n % 3]) begin testsFailed++; $display("[TB] FAIL rr_issue%0d: got seen=%0b gnt=%b pw=%0d, expected 1 %b %0d", n, seen, bus.gnt, bus.dc_password, expGnt, pwTab[n % 3]); end
      bus.dc_unlock = 1'b1;
      waitForDone(doneSeen);
      testsRun++; if (!doneSeen || bus.done !== expGnt || bus.pass !== 1'b1) begin testsFailed++; $display("[TB] FAIL rr_done%0d: got done=%b pass=%b, expected %b 1", n, bus.done, bus.pass, expGnt); end
      bus.dc_unlock = 1'b0;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    testsRun++; if (submitCount - subStart != 6 || doneCount - doneStart != 6) begin testsFailed++; $display("[TB] FAIL rr_counts: got submits=%0d dones=%0d, expected 6 6", submitCount - subStart, doneCount - doneStart); end
    testsRun++; if (multiGnt != multiStart) begin testsFailed++; $display("[TB] FAIL rr_onehot: got %0d multi-hot cycles, expected 0", multiGnt - multiStart); end
  endtask

  task automatic test_timeout();
    bit seen;
    int waitCycles;
    doReset();
    applyStimulus(3'b010, PW_C, PW_B, PW_A);
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b010 || bus.dc_password !== PW_B) begin testsFailed++; $display("[TB] FAIL to_issue: got seen=%0b gnt=%b pw=%0d, expected 1 010 1234", seen, bus.gnt, bus.dc_password); end
    waitCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done !== '0) seen = 1'b1;
      else if (bus.busy === 1'b1) waitCycles++;
    end
    testsRun++; if (waitCycles != 8) begin testsFailed++; $display("[TB] FAIL to_wait_cycles: got %0d, expected 8", waitCycles); end
    testsRun++; if (!seen || bus.done !== 3'b010 || bus.pass !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_report: got done=%b pass=%b, expected 010 0", bus.done, bus.pass); end
    bus.req = '0;
    @(negedge clk);
    testsRun++; if ({bus.busy, bus.lockout, bus.gnt} !== 5'b0) begin testsFailed++; $display("[TB] FAIL to_idle: got busy=%b lockout=%b gnt=%b, expected 0 0 000", bus.busy, bus.lockout, bus.gnt); end
  endtask

  task automatic test_alarm_lockout();
    bit seen;
    int bad;
    doReset();
    applyStimulus(3'b100, PW_C, PW_B, PW_A);
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b100 || bus.dc_password !== PW_C) begin testsFailed++; $display("[TB] FAIL al_issue: got seen=%0b gnt=%b pw=%0d, expected 1 100 9012", seen, bus.gnt, bus.dc_password); end
    @(negedge clk);
    bus.dc_alarm = 1'b1;
    @(negedge clk);
    testsRun++; if (bus.done !== 3'b100 || bus.pass !== 1'b0) begin testsFailed++; $display("[TB] FAIL al_report: got done=%b pass=%b, expected 100 0", bus.done, bus.pass); end
    bus.req = 3'b001;
    @(negedge clk);
    testsRun++; if ({bus.lockout, bus.busy, bus.gnt} !== {1'b1, 1'b1, 3'b000}) begin testsFailed++; $display("[TB] FAIL al_locked: got lockout=%b busy=%b gnt=%b, expected 1 1 000", bus.lockout, bus.busy, bus.gnt); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.gnt !== '0 || bus.dc_submit !== 1'b0 || bus.lockout !== 1'b1) bad++;
    end
    testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL al_hold: got %0d bad cycles, expected 0", bad); end
    bus.dc_alarm = 1'b0;
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b001 || bus.lockout !== 1'b0) begin testsFailed++; $display("[TB] FAIL al_resume: got seen=%0b gnt=%b lockout=%b, expected 1 001 0", seen, bus.gnt, bus.lockout); end
    bus.dc_unlock = 1'b1;
    waitForDone(seen);
    testsRun++; if (!seen || bus.done !== 3'b001 || bus.pass !== 1'b1) begin testsFailed++; $display("[TB] FAIL al_served: got done=%b pass=%b, expected 001 1", bus.done, bus.pass); end
    bus.dc_unlock = 1'b0;
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int doneBefore;
    logic [23:0] obs;
    doReset();
    applyStimulus(3'b001, PW_C, PW_B, PW_A);
    waitForSubmit(seen);
    bus.dc_unlock = 1'b1;
    waitForDone(seen);
    bus.dc_unlock = 1'b0;
    bus.req = 3'b010;
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b010) begin testsFailed++; $display("[TB] FAIL rm_issue: got seen=%0b gnt=%b, expected 1 010", seen, bus.gnt); end
    @(negedge clk);
    doneBefore = doneCount;
    #2 reset = 1'b0;
    #1;
    obs = {bus.gnt, bus.done, bus.pass, bus.busy, bus.lockout, bus.dc_submit, bus.dc_password};
    testsRun++; if (obs !== '0) begin testsFailed++; $display("[TB] FAIL rm_async_clear: got %h, expected 0", obs); end
    repeat (3) @(negedge clk);
    testsRun++; if (doneCount != doneBefore) begin testsFailed++; $display("[TB] FAIL rm_no_done: got %0d done pulses, expected 0", doneCount - doneBefore); end
    reset = 1'b1;
    bus.req = 3'b111;
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b001) begin testsFailed++; $display("[TB] FAIL rm_ptr_zero: got seen=%0b gnt=%b, expected 1 001", seen, bus.gnt); end
    bus.req = '0;
    bus.dc_unlock = 1'b1;
    waitForDone(seen);
    bus.dc_unlock = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dropped_request();
    bit seen;
    doReset();
    applyStimulus(3'b110, PW_C, PW_B, PW_A);
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b010) begin testsFailed++; $display("[TB] FAIL dr_issue: got seen=%0b gnt=%b, expected 1 010", seen, bus.gnt); end
    @(negedge clk);
    bus.req = 3'b100;
    bus.dc_unlock = 1'b1;
    waitForDone(seen);
    testsRun++; if (!seen || bus.done !== 3'b010 || bus.pass !== 1'b1) begin testsFailed++; $display("[TB] FAIL dr_done: got done=%b pass=%b, expected 010 1", bus.done, bus.pass); end
    bus.dc_unlock = 1'b0;
    waitForSubmit(seen);
    testsRun++; if (!seen || bus.gnt !== 3'b100 || bus.dc_password !== PW_C) begin testsFailed++; $display("[TB] FAIL dr_next: got seen=%0b gnt=%b pw=%0d, expected 1 100 9012", seen, bus.gnt, bus.dc_password); end
    bus.dc_unlock = 1'b1;
    waitForDone(seen);
    testsRun++; if (!seen || bus.done !== 3'b100) begin testsFailed++; $display("[TB] FAIL dr_next_done: got done=%b, expected 100", bus.done); end
    bus.dc_unlock = 1'b0;
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.req = '0;
    bus.req_pw = '0;
    bus.dc_unlock = 1'b0;
    bus.dc_alarm = 1'b0;
    test_reset();
    test_correct_password();
    test_round_robin();
    test_timeout();
    test_alarm_lockout();
    test_reset_mid();
    test_dropped_request();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
